// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The slave modport is the loader; the master modport is the source/memory side.
interface program_loader_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic [7:0]            rx_data_i;
  logic                  rx_valid_i;
  logic                  rx_ready_o;
  logic                  imem_we_o;
  logic [ADDR_WIDTH-1:0] imem_addr_o;
  logic [31:0]           imem_wdata_o;

  modport slave (
    input  rx_data_i,
    input  rx_valid_i,
    output rx_ready_o,
    output imem_we_o,
    output imem_addr_o,
    output imem_wdata_o
  );

  modport master (
    output rx_data_i,
    output rx_valid_i,
    input  rx_ready_o,
    input  imem_we_o,
    input  imem_addr_o,
    input  imem_wdata_o
  );
endinterface

// File: rtl/program_loader.sv
// Boot loader: receives a framed byte stream (16-bit word count, big-endian
// payload words, XOR checksum), writes the words into instruction memory and
// releases the core from reset once the image checksum matches.
module program_loader #(
  parameter int unsigned MEMORY_DEPTH = 256,
  parameter int unsigned ADDR_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  program_loader_if.slave       bus,
  output logic                  cpu_reset_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [15:0]           words_loaded_o
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StHdrHi = 3'd1;
  localparam logic [2:0] StHdrLo = 3'd2;
  localparam logic [2:0] StData  = 3'd3;
  localparam logic [2:0] StCsum  = 3'd4;
  localparam logic [2:0] StRun   = 3'd5;
  localparam logic [2:0] StError = 3'd6;

  logic [2:0]            state_q, state_d;
  logic [15:0]           count_q, count_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [23:0]           word_buf_q, word_buf_d;
  logic [7:0]            xor_q, xor_d;
  logic [15:0]           words_q, words_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  cpu_reset_q, busy_q, done_q, error_q;

  logic                  rx_ready;
  logic                  xfer;
  logic [15:0]           count_rx;

  // Stream is accepted in every loading state, independent of rx_valid_i.
  assign rx_ready = (state_q == StHdrHi) || (state_q == StHdrLo) ||
                    (state_q == StData)  || (state_q == StCsum);
  assign xfer     = rx_ready && bus.rx_valid_i;
  assign count_rx = {count_q[15:8], bus.rx_data_i};

  // Next-state: frame parsing, word assembly and checksum accumulation.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    byte_cnt_d = byte_cnt_q;
    word_buf_d = word_buf_q;
    xor_d      = xor_q;
    words_d    = words_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;

    if (start_i) begin
      // Restart wins over any byte arriving in the same cycle.
      state_d    = StHdrHi;
      byte_cnt_d = 2'd0;
      xor_d      = 8'd0;
      words_d    = 16'd0;
    end else if (xfer) begin
      case (state_q)
        StHdrHi: begin
          count_d = {bus.rx_data_i, 8'd0};
          xor_d   = xor_q ^ bus.rx_data_i;
          state_d = StHdrLo;
        end
        StHdrLo: begin
          count_d = count_rx;
          xor_d   = xor_q ^ bus.rx_data_i;
          if ({16'd0, count_rx} > MEMORY_DEPTH) begin
            state_d = StError;
          end else if (count_rx == 16'd0) begin
            state_d = StCsum;
          end else begin
            state_d = StData;
          end
        end
        StData: begin
          xor_d = xor_q ^ bus.rx_data_i;
          if (byte_cnt_q == 2'd3) begin
            we_d       = 1'b1;
            wdata_d    = {word_buf_q, bus.rx_data_i};
            addr_d     = ADDR_WIDTH'({words_q, 2'b00});
            words_d    = words_q + 16'd1;
            byte_cnt_d = 2'd0;
            if (words_q + 16'd1 == count_q) begin
              state_d = StCsum;
            end
          end else begin
            word_buf_d = {word_buf_q[15:0], bus.rx_data_i};
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
        StCsum: begin
          state_d = (bus.rx_data_i == xor_q) ? StRun : StError;
        end
        default: ;
      endcase
    end
  end

  // State and registered outputs; status flags decode the upcoming state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      count_q     <= 16'd0;
      byte_cnt_q  <= 2'd0;
      word_buf_q  <= 24'd0;
      xor_q       <= 8'd0;
      words_q     <= 16'd0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      byte_cnt_q  <= byte_cnt_d;
      word_buf_q  <= word_buf_d;
      xor_q       <= xor_d;
      words_q     <= words_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_reset_q <= (state_d != StRun);
      busy_q      <= (state_d == StHdrHi) || (state_d == StHdrLo) ||
                     (state_d == StData)  || (state_d == StCsum);
      done_q      <= (state_d == StRun);
      error_q     <= (state_d == StError);
    end
  end

  assign bus.rx_ready_o   = rx_ready;
  assign bus.imem_we_o    = we_q;
  assign bus.imem_addr_o  = addr_q;
  assign bus.imem_wdata_o = wdata_q;
  assign cpu_reset_o      = cpu_reset_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign error_o          = error_q;
  assign words_loaded_o   = words_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomised bench for program_loader: a byte-position model of the frame
// predicts every output each cycle; directed frames pin known results.
module tb_program_loader;

  localparam int unsigned Depth = 256;
  localparam int PIdle = 0;
  localparam int PLoad = 1;
  localparam int PRun  = 2;
  localparam int PErr  = 3;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic        cpu_reset_o, busy_o, done_o, error_o;
  logic [15:0] words_loaded_o;

  program_loader_if #(.ADDR_WIDTH(32)) bus ();

  program_loader #(
    .MEMORY_DEPTH(Depth),
    .ADDR_WIDTH  (32)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start_i       (start_i),
    .bus           (bus),
    .cpu_reset_o   (cpu_reset_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .error_o       (error_o),
    .words_loaded_o(words_loaded_o)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Model state: what has been received in the current frame.
  int          m_phase = PIdle;
  bq_t         m_bytes;
  int          m_n = 0;
  logic        m_we = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [15:0] m_wl = '0;
  logic [31:0] m_mem [Depth];
  logic [31:0] d_mem [Depth];
  logic [63:0] wlog[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: outputs follow from the position of each accepted byte in the frame.
  always @(posedge clk) begin
    int k;
    logic [7:0] x;
    m_we = 1'b0;
    if (reset) begin
      m_phase = PIdle; m_bytes.delete(); m_wl = '0; m_addr = '0; m_wdata = '0; m_n = 0;
    end else if (start_i) begin
      m_phase = PLoad; m_bytes.delete(); m_wl = '0;
    end else if (m_phase == PLoad && bus.rx_valid_i) begin
      m_bytes.push_back(bus.rx_data_i);
      k = m_bytes.size();
      if (k == 2) begin
        m_n = {m_bytes[0], m_bytes[1]};
        if (m_n > Depth) m_phase = PErr;
      end else if (k > 2 && k <= 2 + 4 * m_n) begin
        if ((k - 2) % 4 == 0) begin
          m_we    = 1'b1;
          m_addr  = 32'(4 * ((k - 2) / 4 - 1));
          m_wdata = {m_bytes[k-4], m_bytes[k-3], m_bytes[k-2], m_bytes[k-1]};
          m_wl    = m_wl + 16'd1;
          m_mem[m_addr[9:2]] = m_wdata;
        end
      end else if (k == 3 + 4 * m_n) begin
        x = 8'd0;
        for (int i = 0; i < k - 1; i++) x = x ^ m_bytes[i];
        m_phase = (m_bytes[k-1] == x) ? PRun : PErr;
      end
    end
  end

  // Compare every output against the model each cycle, and log DUT writes.
  always @(negedge clk) begin
    logic [127:0] act, exp;
    if (chk_en) begin
      act = {42'd0, bus.rx_ready_o, bus.imem_we_o, cpu_reset_o, busy_o, done_o, error_o,
             words_loaded_o, bus.imem_addr_o, bus.imem_wdata_o};
      exp = {42'd0, m_phase == PLoad, m_we, m_phase != PRun, m_phase == PLoad,
             m_phase == PRun, m_phase == PErr, m_wl, m_addr, m_wdata};
      check("cycle", act, exp);
    end
    if (bus.imem_we_o === 1'b1) begin
      wlog.push_back({bus.imem_addr_o, bus.imem_wdata_o});
      d_mem[bus.imem_addr_o[9:2]] = bus.imem_wdata_o;
    end
  end

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    int t;
    while (int'($urandom_range(99)) < gap_pct) begin
      bus.rx_valid_i = 1'b0;
      bus.rx_data_i  = 8'($urandom);
      @(negedge clk);
    end
    bus.rx_valid_i = 1'b1;
    bus.rx_data_i  = b;
    t = 0;
    while (bus.rx_ready_o !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (bus.rx_ready_o !== 1'b1) begin
      n_cmp++;
      n_fail++;
      $display("FAIL ready_timeout: got rx_ready_o=%b expected 1 at %0t", bus.rx_ready_o, $time);
    end
    @(negedge clk);
    bus.rx_valid_i = 1'b0;
  endtask

  task automatic send_frame(input bq_t f, input int gap_pct);
    foreach (f[i]) send_byte(f[i], gap_pct);
  endtask

  task automatic make_frame(input int n, input bit bad, output bq_t f);
    logic [7:0] x;
    logic [15:0] n16;
    n16 = 16'(n);
    f = {};
    f.push_back(n16[15:8]);
    f.push_back(n16[7:0]);
    for (int i = 0; i < 4 * n; i++) f.push_back(8'($urandom));
    x = 8'd0;
    foreach (f[i]) x = x ^ f[i];
    if (bad) x = x ^ 8'(1 + $urandom_range(254));
    f.push_back(x);
  endtask

  task automatic mem_check(input string name);
    int errs = 0;
    for (int i = 0; i < Depth; i++) if (d_mem[i] !== m_mem[i]) errs++;
    check(name, 128'(errs), 128'd0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bq_t f, g;
    bit  bad;
    int  n;
    for (int i = 0; i < Depth; i++) begin
      m_mem[i] = 32'hDEAD_BEEF;
      d_mem[i] = 32'hDEAD_BEEF;
    end
    reset = 1'b1; start_i = 1'b0; bus.rx_valid_i = 1'b0; bus.rx_data_i = 8'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    check("rst_ready", bus.rx_ready_o, 0);
    check("rst_we", bus.imem_we_o, 0);
    check("rst_addr", bus.imem_addr_o, 0);
    check("rst_wdata", bus.imem_wdata_o, 0);
    check("rst_cpu_reset", cpu_reset_o, 1);
    check("rst_flags", {busy_o, done_o, error_o}, 0);
    check("rst_words", words_loaded_o, 0);

    // Good image; XOR of all preceding frame bytes is 0x04.
    wlog.delete();
    pulse_start();
    send_frame('{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h21, 8'h09, 8'h00, 8'h03, 8'h04}, 30);
    check("good_nwrites", wlog.size(), 2);
    check("good_w0", wlog[0], {32'h0, 32'h2008_0005});
    check("good_w1", wlog[1], {32'h4, 32'h2109_0003});
    check("good_status", {cpu_reset_o, done_o, error_o, busy_o}, 4'b0100);
    check("good_words", words_loaded_o, 2);

    // Bad checksum: words still written, then error.
    wlog.delete();
    pulse_start();
    send_frame('{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h21, 8'h09, 8'h00, 8'h03, 8'h08}, 0);
    check("bad_nwrites", wlog.size(), 2);
    check("bad_status", {cpu_reset_o, done_o, error_o}, 3'b101);

    // Oversize count: error straight after the header, no writes.
    wlog.delete();
    pulse_start();
    send_frame('{8'h01, 8'h01}, 0);
    repeat (2) @(negedge clk);
    check("big_nwrites", wlog.size(), 0);
    check("big_status", {bus.rx_ready_o, error_o, cpu_reset_o}, 3'b011);

    // Empty image.
    wlog.delete();
    pulse_start();
    send_frame('{8'h00, 8'h00, 8'h00}, 0);
    check("empty_status", {done_o, cpu_reset_o, words_loaded_o}, {1'b1, 1'b0, 16'd0});
    check("empty_nwrites", wlog.size(), 0);

    // Restart mid-word with a coincident byte, then a fresh frame.
    make_frame(3, 1'b0, g);
    make_frame(3, 1'b0, f);
    wlog.delete();
    pulse_start();
    for (int i = 0; i < 7; i++) send_byte(g[i], 40);
    start_i = 1'b1; bus.rx_valid_i = 1'b1; bus.rx_data_i = 8'hAA;
    @(negedge clk);
    start_i = 1'b0; bus.rx_valid_i = 1'b0;
    send_frame(f, 40);
    check("restart_nwrites", wlog.size(), 4);
    check("restart_first", wlog[1], {32'h0, f[2], f[3], f[4], f[5]});
    check("restart_status", {done_o, words_loaded_o}, {1'b1, 16'd3});
    mem_check("restart_mem");

    // Reset held two cycles in the middle of the payload.
    make_frame(4, 1'b0, f);
    pulse_start();
    for (int i = 0; i < 9; i++) send_byte(f[i], 0);
    wlog.delete();
    reset = 1'b1; bus.rx_valid_i = 1'b1; bus.rx_data_i = f[9];
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (6) begin
      bus.rx_data_i = 8'($urandom);
      @(negedge clk);
    end
    bus.rx_valid_i = 1'b0;
    check("midrst_nwrites", wlog.size(), 0);
    check("midrst_status", {cpu_reset_o, busy_o, words_loaded_o}, {1'b1, 1'b0, 16'd0});

    // Random frames, including a full-depth image.
    for (int r = 0; r < 9; r++) begin
      n   = (r == 4) ? int'(Depth) : int'($urandom_range(1, 12));
      bad = ($urandom_range(3) == 0);
      make_frame(n, bad, f);
      wlog.delete();
      pulse_start();
      send_frame(f, 25);
      repeat (2) @(negedge clk);
      check("rand_nwrites", wlog.size(), n);
      check("rand_status", {done_o, error_o}, {!bad, bad});
      mem_check("rand_mem");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
